// File: rtl/lsu_mem64_pkg.sv
// Shared types and helpers for the 64-bit load/store unit: FSM states,
// FUNCT3 encodings and the access legality/alignment check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // True when the encoding is legal for the direction and the address is
    // naturally aligned for the access size carried in funct3[1:0].
    function automatic logic access_legal(
        input logic       we,
        input logic [2:0] funct3,
        input logic [2:0] addr_lo
    );
        logic illegal;
        logic misaligned;
        illegal = we ? funct3[2] : (funct3 == 3'b111);
        case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo[1:0];
            default: misaligned = |addr_lo;
        endcase
        return !illegal && !misaligned;
    endfunction

endpackage

// File: rtl/lsu_mem64_byte_lane.sv
// Combinational lane logic: extract and sign/zero-extend a load from a
// memory doubleword, and merge store bytes into a read-back doubleword.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [2:0]  i_off,
    input  logic [63:0] i_rdword,
    input  logic [63:0] i_mbuf,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_load,
    output logic [63:0] o_merged
);

    logic [63:0] w_shifted;
    logic [63:0] w_wshift;
    logic [3:0]  w_nbytes;
    logic [3:0]  w_lane_end;
    logic [7:0]  w_sel;
    logic        w_signed;

    assign w_shifted  = i_rdword >> {i_off, 3'b000};
    assign w_wshift   = i_wdata << {i_off, 3'b000};
    assign w_nbytes   = 4'd1 << i_funct3[1:0];
    assign w_lane_end = {1'b0, i_off} + w_nbytes;
    assign w_signed   = ~i_funct3[2];

    always_comb begin
        o_load = w_shifted;
        case (i_funct3)
            F3_B, F3_BU: o_load = {{56{w_signed & w_shifted[7]}},  w_shifted[7:0]};
            F3_H, F3_HU: o_load = {{48{w_signed & w_shifted[15]}}, w_shifted[15:0]};
            F3_W, F3_WU: o_load = {{32{w_signed & w_shifted[31]}}, w_shifted[31:0]};
            default:     o_load = w_shifted;
        endcase
    end

    // A byte lane takes store data when it lies inside [off, off+size).
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign w_sel[gi] = (4'(gi) >= {1'b0, i_off}) && (4'(gi) < w_lane_end);
            assign o_merged[8*gi +: 8] = w_sel[gi] ? w_wshift[8*gi +: 8]
                                                  : i_mbuf[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/lsu_mem64.sv
// Load/store unit for the multicycle datapath: one access per request,
// read-modify-write for sub-doubleword stores, single DONE pulse per access.
module lsu_mem64
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        WE,
    input  logic [2:0]  FUNCT3,
    input  logic [63:0] ADDR,
    input  logic [63:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        FAULT,
    output logic [63:0] RDATA,
    output logic [63:0] MEM_RADDR,
    output logic [63:0] MEM_WADDR,
    output logic [63:0] MEM_DIN,
    input  logic [63:0] MEM_DOUT,
    output logic        MEM_WR
);

    lsu_state_t  r_state;
    lsu_state_t  w_next_state;
    logic [1:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_fault;
    logic [63:0] r_rdata;
    logic [63:0] r_mbuf;

    logic        w_accept;
    logic        w_legal;
    logic        w_read_last;
    logic [63:0] w_load;
    logic [63:0] w_merged;

    assign w_accept    = (r_state == IDLE) && REQ;
    assign w_legal     = access_legal(WE, FUNCT3, ADDR[2:0]);
    assign w_read_last = (r_cnt == 2'(MEM_LAT - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (REQ) begin
                    if (!w_legal)
                        w_next_state = RESP;
                    else if (WE && (FUNCT3 == F3_D))
                        w_next_state = WRITE;
                    else
                        w_next_state = READ;
                end
            end
            READ: begin
                if (w_read_last)
                    w_next_state = r_we ? WRITE : RESP;
            end
            WRITE:   w_next_state = RESP;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_fault <= 1'b0;
            r_rdata <= 64'd0;
            r_mbuf  <= 64'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_we    <= WE;
                r_f3    <= FUNCT3;
                r_addr  <= ADDR;
                r_wdata <= WDATA;
                r_fault <= !w_legal;
            end
            if ((r_state == READ) && !w_read_last)
                r_cnt <= r_cnt + 2'd1;
            else
                r_cnt <= 2'd0;
            // The edge ending READ samples memory: loads update RDATA, stores
            // park the old doubleword for the merge.
            if ((r_state == READ) && w_read_last) begin
                if (r_we)
                    r_mbuf  <= MEM_DOUT;
                else
                    r_rdata <= w_load;
            end
        end
    end

    lsu_byte_lane u_lane (
        .i_funct3 (r_f3),
        .i_off    (r_addr[2:0]),
        .i_rdword (MEM_DOUT),
        .i_mbuf   (r_mbuf),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    assign BUSY      = (r_state != IDLE);
    assign DONE      = (r_state == RESP);
    assign FAULT     = (r_state == RESP) && r_fault;
    assign MEM_WR    = (r_state == WRITE);
    assign RDATA     = r_rdata;
    assign MEM_RADDR = {r_addr[63:3], 3'b000};
    assign MEM_WADDR = {r_addr[63:3], 3'b000};
    assign MEM_DIN   = w_merged;

endmodule

// File: tb/tb_lsu_mem64.sv
// Scoreboard bench for lsu_mem64: a byte-level reference model predicts each
// access; monitors compare on DONE and on every memory write strobe.
module tb_lsu_mem64;

    localparam int L = 1;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        REQ = 1'b0;
    logic        WE = 1'b0;
    logic [2:0]  FUNCT3 = 3'd0;
    logic [63:0] ADDR = 64'd0;
    logic [63:0] WDATA = 64'd0;
    logic        BUSY, DONE, FAULT, MEM_WR;
    logic [63:0] RDATA, MEM_RADDR, MEM_WADDR, MEM_DIN, MEM_DOUT;

    lsu_mem64 #(.MEM_LAT(L)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ       (REQ),
        .WE        (WE),
        .FUNCT3    (FUNCT3),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .FAULT     (FAULT),
        .RDATA     (RDATA),
        .MEM_RADDR (MEM_RADDR),
        .MEM_WADDR (MEM_WADDR),
        .MEM_DIN   (MEM_DIN),
        .MEM_DOUT  (MEM_DOUT),
        .MEM_WR    (MEM_WR)
    );

    always #5 CLK = ~CLK;

    // Environment memory: 16 doublewords, address stable for the whole READ.
    logic [63:0] mem [16];
    logic [63:0] ref_mem [16];
    assign MEM_DOUT = mem[MEM_RADDR[6:3]];
    always @(posedge CLK) if (MEM_WR) mem[MEM_WADDR[6:3]] <= MEM_DIN;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic        fault;
        logic [63:0] rdata;
        logic [63:0] raddr;
        int          cyc;
    } exp_t;
    typedef struct {
        logic [63:0] waddr;
        logic [63:0] din;
        int          cyc;
    } wexp_t;

    exp_t  exp_q[$];
    wexp_t wq[$];
    exp_t  mon_e;
    wexp_t mon_w;
    int    tests = 0;
    int    fails = 0;
    int    ntxn  = 0;
    logic [63:0] model_rdata = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            if (DONE) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: DONE=1 at cycle %0d with no request pending", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    ntxn++;
                    chk("fault", {63'd0, FAULT}, {63'd0, mon_e.fault});
                    chk("rdata", RDATA, mon_e.rdata);
                    chk("raddr", MEM_RADDR, mon_e.raddr);
                    chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                    $display("[TB] txn %0d done cyc=%0d fault=%0b rdata=%h raddr=%h",
                             ntxn, cyc, FAULT, RDATA, MEM_RADDR);
                end
            end else if (FAULT) begin
                tests++; fails++;
                $display("FAIL fault_without_done: FAULT=1 DONE=0 at cycle %0d", cyc);
            end
            if (MEM_WR) begin
                if (wq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: MEM_WR=1 at cycle %0d addr %h", cyc, MEM_WADDR);
                end else begin
                    mon_w = wq.pop_front();
                    chk("waddr", MEM_WADDR, mon_w.waddr);
                    chk("din", MEM_DIN, mon_w.din);
                    chk("wr_cycle", 64'(cyc), 64'(mon_w.cyc));
                    $display("[TB] write cyc=%0d addr=%h din=%h", cyc, MEM_WADDR, MEM_DIN);
                end
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge CLK);
        while (BUSY && k < 40) begin
            @(negedge CLK);
            k++;
        end
        if (BUSY) begin
            tests++; fails++;
            $display("FAIL idle_timeout: BUSY still 1 after %0d cycles", k);
        end
    endtask

    // Reference: size = 2^funct3[1:0] bytes, little-endian lanes from addr[2:0].
    function automatic logic [63:0] store_bytes(input logic [63:0] dw, input logic [2:0] off,
                                                input int n, input logic [63:0] wd);
        logic [63:0] r = dw;
        for (int i = 0; i < n; i++) r[8*(int'(off)+i) +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input bit hold);
        int          t0, n, idx, lat, k;
        logic [2:0]  off;
        bit          flt;
        logic [63:0] dw, v, nd;
        wait_idle();
        t0  = cyc;
        off = addr[2:0];
        n   = 1 << f3[1:0];
        idx = int'(addr[6:3]);
        dw  = ref_mem[idx];
        flt = (we ? f3[2] : (f3 == 3'b111)) || ((int'(off) % n) != 0);
        if (flt)             lat = 1;
        else if (!we)        lat = L + 1;
        else if (f3 == 3'd3) lat = 2;
        else                 lat = L + 2;
        if (!flt && !we) begin
            v = 64'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = dw[8*(int'(off)+i) +: 8];
            if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
            model_rdata = v;
        end
        if (!flt && we) begin
            nd = store_bytes(dw, off, n, wdata);
            ref_mem[idx] = nd;
            wq.push_back('{{addr[63:3], 3'b000}, nd, t0 + ((f3 == 3'd3) ? 1 : L + 1)});
        end
        exp_q.push_back('{flt, model_rdata, {addr[63:3], 3'b000}, t0 + lat});
        REQ = 1'b1; WE = we; FUNCT3 = f3; ADDR = addr; WDATA = wdata;
        @(posedge CLK);
        #1;
        ADDR = {$urandom, $urandom}; WDATA = {$urandom, $urandom};
        WE = 1'($urandom); FUNCT3 = 3'($urandom);
        if (!hold) begin
            REQ = 1'b0;
        end else begin
            k = 0;
            @(negedge CLK);
            while (BUSY && k < 40) begin
                @(negedge CLK);
                k++;
            end
            REQ = 1'b0;
        end
    endtask

    initial begin
        int          t0, k;
        logic [63:0] wd, nd;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = {$urandom, $urandom};
        end
        ref_mem[2] = 64'h8877665544332211;
        for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];

        #2;
        chk("rst_busy", {63'd0, BUSY}, 64'd0);
        chk("rst_done", {63'd0, DONE}, 64'd0);
        chk("rst_fault", {63'd0, FAULT}, 64'd0);
        chk("rst_memwr", {63'd0, MEM_WR}, 64'd0);
        chk("rst_rdata", RDATA, 64'd0);
        chk("rst_din", MEM_DIN, 64'd0);
        chk("rst_raddr", MEM_RADDR, 64'd0);
        chk("rst_waddr", MEM_WADDR, 64'd0);
        @(negedge CLK);
        RESET = 1'b1;

        issue(1'b0, 3'b011, 64'h10, 64'd0, 1'b0);          // ld
        issue(1'b0, 3'b000, 64'h17, 64'd0, 1'b0);          // lb
        issue(1'b0, 3'b100, 64'h17, 64'd0, 1'b0);          // lbu
        issue(1'b0, 3'b001, 64'h16, 64'd0, 1'b0);          // lh
        issue(1'b1, 3'b001, 64'h12, 64'hAAAABBBB, 1'b0);   // sh
        issue(1'b0, 3'b011, 64'h10, 64'd0, 1'b0);          // ld readback
        issue(1'b0, 3'b010, 64'h12, 64'd0, 1'b0);          // misaligned lw
        issue(1'b1, 3'b100, 64'h10, 64'h1234, 1'b0);       // illegal store
        issue(1'b0, 3'b111, 64'h20, 64'd0, 1'b0);          // illegal load
        issue(1'b1, 3'b011, 64'h28, 64'h0123456789ABCDEF, 1'b0); // sd
        issue(1'b0, 3'b011, 64'h18, 64'd0, 1'b1);          // REQ held high

        // Store cut by reset in its WRITE cycle: no DONE, memory untouched.
        wait_idle();
        t0 = cyc;
        wd = {$urandom, $urandom};
        nd = store_bytes(ref_mem[6], 3'd2, 2, wd);
        wq.push_back('{64'h30, nd, t0 + L + 1});
        REQ = 1'b1; WE = 1'b1; FUNCT3 = 3'b001; ADDR = 64'h32; WDATA = wd;
        @(posedge CLK);
        #1;
        REQ = 1'b0;
        k = 0;
        while (!MEM_WR && k < 20) begin
            @(posedge CLK);
            #1;
            k++;
        end
        chk("abort_reach_write", {63'd0, MEM_WR}, 64'd1);
        @(negedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        chk("abort_memwr", {63'd0, MEM_WR}, 64'd0);
        chk("abort_busy", {63'd0, BUSY}, 64'd0);
        chk("abort_done", {63'd0, DONE}, 64'd0);
        chk("abort_rdata", RDATA, 64'd0);
        chk("abort_din", MEM_DIN, 64'd0);
        chk("abort_raddr", MEM_RADDR, 64'd0);
        model_rdata = 64'd0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (4) @(negedge CLK);
        issue(1'b0, 3'b011, 64'h30, 64'd0, 1'b0);          // memory unchanged

        for (int t = 0; t < 150; t++) begin
            issue(1'($urandom), 3'($urandom), 64'($urandom_range(0, 127)),
                  {$urandom, $urandom}, 1'($urandom_range(0, 7) == 0));
        end

        k = 0;
        while ((exp_q.size() != 0 || wq.size() != 0) && k < 50) begin
            @(negedge CLK);
            k++;
        end
        repeat (3) @(negedge CLK);
        chk("drain_resp_queue", 64'(exp_q.size()), 64'd0);
        chk("drain_write_queue", 64'(wq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
